// File: rtl/tdc_pkg.sv
// Shared types and helpers for the multi-channel coarse TDC core.
package tdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_MEASURE,
        ST_DRAIN
    } tdc_state_e;

    typedef enum logic {
        MODE_SINGLE = 1'b0,
        MODE_CONT   = 1'b1
    } tdc_mode_e;

    function automatic int ch_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic int rec_width(input int nch, input int cnt_w);
        return ch_width(nch) + 1 + cnt_w;
    endfunction

endpackage

// File: rtl/tdc_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input followed by a registered
// rising-edge detector; input rise to pulse takes SYNC_STAGES+1 cycles.
module tdc_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= sync[SYNC_STAGES-1];
            rise <= sync[SYNC_STAGES-1] & ~prev;
        end
    end

endmodule

// File: rtl/tdc_mc_core.sv
// Multi-channel coarse TDC: one shared start, NCH stops, interval in clock
// cycles, saturating timeout and a record FIFO on a valid/ready port.
//
// state   | meaning
// IDLE    | waiting for arm request
// ARMED   | waiting for start edge
// MEASURE | counting, capturing first stop edge per channel
// DRAIN   | pushing one record per cycle, channel 0 upward
module tdc_mc_core
    import tdc_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int CNT_W       = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_i,
    input  logic [NCH-1:0]                    stop_i,
    input  logic                              arm_i,
    input  logic                              mode_i,
    output logic                              busy_o,
    output logic                              rec_valid_o,
    input  logic                              rec_ready_i,
    output logic [rec_width(NCH, CNT_W)-1:0]  rec_data_o,
    output logic                              missed_o
);

    localparam int CH_W  = ch_width(NCH);
    localparam int REC_W = rec_width(NCH, CNT_W);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic           start_edge;
    logic [NCH-1:0] stop_edge;

    tdc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (start_i),
        .rise (start_edge)
    );

    for (genvar g = 0; g < NCH; g++) begin : g_stop
        tdc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stop (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (stop_i[g]),
            .rise (stop_edge[g])
        );
    end

    tdc_state_e                    state, state_nx;
    logic [CNT_W-1:0]              cnt, cnt_nx;
    logic [NCH-1:0]                stopped, stopped_nx;
    logic [NCH-1:0][CNT_W-1:0]     cap_cnt, cap_cnt_nx;
    logic [NCH-1:0]                cap_ovf, cap_ovf_nx;
    logic [CH_W-1:0]               idx, idx_nx;
    logic                          missed, missed_nx;
    logic                          push, pop, full;
    logic [REC_W-1:0]              push_data;

    logic [FIFO_DEPTH-1:0][REC_W-1:0] mem;
    logic [AW-1:0]                    wr_ptr, rd_ptr;
    logic [AW:0]                      fcount;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        stopped_nx = stopped;
        cap_cnt_nx = cap_cnt;
        cap_ovf_nx = cap_ovf;
        idx_nx     = idx;
        missed_nx  = missed;
        push       = 1'b0;
        push_data  = {idx, cap_ovf[idx], cap_cnt[idx]};

        unique case (state)
            ST_IDLE: begin
                if (arm_i) begin
                    state_nx  = ST_ARMED;
                    missed_nx = 1'b0;
                end
            end
            ST_ARMED: begin
                if (start_edge) begin
                    state_nx   = ST_MEASURE;
                    cnt_nx     = '0;
                    stopped_nx = '0;
                    cap_cnt_nx = '0;
                    cap_ovf_nx = '0;
                end
            end
            ST_MEASURE: begin
                cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                for (int c = 0; c < NCH; c++) begin
                    if (stop_edge[c] && !stopped[c]) begin
                        stopped_nx[c] = 1'b1;
                        cap_cnt_nx[c] = cnt + 1'b1;
                    end
                end
                if (&stopped_nx) begin
                    state_nx = ST_DRAIN;
                end else if (cnt_nx == CNT_MAX) begin
                    // Counter hits full scale: channels still open become overflow records.
                    state_nx = ST_DRAIN;
                    for (int c = 0; c < NCH; c++) begin
                        if (!stopped_nx[c]) begin
                            cap_ovf_nx[c] = 1'b1;
                            cap_cnt_nx[c] = CNT_MAX;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (!full || pop) begin
                    push = 1'b1;
                    if (idx == CH_W'(NCH - 1)) begin
                        idx_nx   = '0;
                        state_nx = (tdc_mode_e'(mode_i) == MODE_CONT) ? ST_ARMED : ST_IDLE;
                    end else begin
                        idx_nx = idx + 1'b1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase

        if (start_edge && state != ST_ARMED) missed_nx = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            stopped <= '0;
            cap_cnt <= '0;
            cap_ovf <= '0;
            idx     <= '0;
            missed  <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            stopped <= stopped_nx;
            cap_cnt <= cap_cnt_nx;
            cap_ovf <= cap_ovf_nx;
            idx     <= idx_nx;
            missed  <= missed_nx;
        end
    end

    assign full = (fcount == (AW + 1)'(FIFO_DEPTH));
    assign pop  = rec_valid_o & rec_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcount <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fcount <= fcount + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    assign busy_o      = (state != ST_IDLE);
    assign rec_valid_o = (fcount != '0);
    assign rec_data_o  = mem[rd_ptr];
    assign missed_o    = missed;

endmodule

// File: tb/tb_tdc_mc_core.sv
// Self-checking bench for tdc_mc_core: directed scenarios with literal records
// plus randomized shots checked against an interval-arithmetic model.
module tb_tdc_mc_core;

    localparam int NCH         = 4;
    localparam int CNT_W       = 8;
    localparam int FIFO_DEPTH  = 2;
    localparam int SYNC_STAGES = 2;
    localparam int CH_W        = 2;
    localparam int REC_W       = CH_W + 1 + CNT_W;
    localparam int CMAX        = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_i;
    logic [NCH-1:0]   stop_i;
    logic             arm_i;
    logic             mode_i;
    logic             busy_o;
    logic             rec_valid_o;
    logic             rec_ready_i;
    logic [REC_W-1:0] rec_data_o;
    logic             missed_o;

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [REC_W-1:0] exp_q[$];
    bit               rand_ready = 1'b0;
    bit               ready_val  = 1'b1;

    tdc_mc_core #(
        .NCH(NCH), .CNT_W(CNT_W), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
        .arm_i(arm_i), .mode_i(mode_i), .busy_o(busy_o),
        .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i),
        .rec_data_o(rec_data_o), .missed_o(missed_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Record for one channel: first stop rise 1..CMAX cycles after the start rise
    // gives that interval; otherwise the channel times out.
    function automatic logic [REC_W-1:0] model_rec(input int ch, input int off, input bit extra);
        int rises[2];
        int first = -1;
        rises[0] = off;
        rises[1] = (extra && off >= 0) ? off + 5 : -1;
        for (int i = 0; i < 2; i++)
            if (first < 0 && rises[i] >= 1 && rises[i] <= CMAX) first = rises[i];
        if (first < 0) return {CH_W'(ch), 1'b1, CNT_W'(CMAX)};
        return {CH_W'(ch), 1'b0, CNT_W'(first)};
    endfunction

    task automatic drive_rel(input int rel, input int offs[NCH], input bit extra);
        start_i = (rel >= 0 && rel < 3);
        for (int c = 0; c < NCH; c++)
            stop_i[c] = (offs[c] >= 0) &&
                        ((rel >= offs[c] && rel < offs[c] + 2) ||
                         (extra && rel >= offs[c] + 5 && rel < offs[c] + 7));
    endtask

    // Single-shot measurement; returns cycles from start rise to first record visible.
    task automatic shot(input int offs[NCH], input bit extra, input int stall, output int t_valid);
        int  last;
        int  rel;
        bit  done;
        mode_i = 1'b0;
        arm_i  = 1'b1;
        tick(1);
        arm_i  = 1'b0;
        chk("busy_after_arm", busy_o, 1);
        last = 6;
        for (int c = 0; c < NCH; c++) if (offs[c] + 7 > last) last = offs[c] + 7;
        if (stall > 0) begin
            rand_ready = 1'b0;
            ready_val  = 1'b0;
        end
        t_valid = -1;
        rel     = 0;
        done    = 1'b0;
        while (!done) begin
            drive_rel(rel, offs, extra);
            if (stall > 0 && rel == stall) ready_val = 1'b1;
            if (t_valid < 0 && rec_valid_o) t_valid = rel;
            if (stall > 0 && rel == stall - 1) begin
                chk("stall_busy", busy_o, 1);
                chk("stall_valid", rec_valid_o, 1);
            end
            if (rel > last && !busy_o && !rec_valid_o && exp_q.size() == 0) begin
                done = 1'b1;
            end else if (rel >= 700) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drain_timeout: busy %0b valid %0b, %0d records still expected",
                         busy_o, rec_valid_o, exp_q.size());
                exp_q.delete();
                done = 1'b1;
            end else begin
                tick(1);
                rel++;
            end
        end
    endtask

    initial begin
        rec_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            rec_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
        end
    end

    always @(negedge clk) begin
        if (rst_n && rec_valid_o && rec_ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rec_unexpected: got %0h want none", rec_data_o);
            end else begin
                chk("rec_data", rec_data_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int o[NCH];
        int tv;
        bit busy_low;
        rst_n = 1'b0; start_i = 1'b0; stop_i = '0; arm_i = 1'b0; mode_i = 1'b0;
        tick(3);
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", rec_valid_o, 0);
        chk("rst_data", rec_data_o, 0);
        chk("rst_missed", missed_o, 0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_busy", busy_o, 0);

        // Four stops in order, single shot
        o = '{5, 9, 12, 20};
        exp_q.push_back({2'd0, 1'b0, 8'd5});
        exp_q.push_back({2'd1, 1'b0, 8'd9});
        exp_q.push_back({2'd2, 1'b0, 8'd12});
        exp_q.push_back({2'd3, 1'b0, 8'd20});
        shot(o, 1'b0, 0, tv);
        chk("first_rec_latency", tv, 25);

        // Timeout with a single stopped channel
        o = '{-1, 30, -1, -1};
        exp_q.push_back({2'd0, 1'b1, 8'd255});
        exp_q.push_back({2'd1, 1'b0, 8'd30});
        exp_q.push_back({2'd2, 1'b1, 8'd255});
        exp_q.push_back({2'd3, 1'b1, 8'd255});
        shot(o, 1'b0, 0, tv);
        chk("timeout_rec_latency", tv, 260);

        // Back-pressure: FIFO fills, DRAIN stalls, nothing lost
        o = '{3, 4, 5, 6};
        exp_q.push_back({2'd0, 1'b0, 8'd3});
        exp_q.push_back({2'd1, 1'b0, 8'd4});
        exp_q.push_back({2'd2, 1'b0, 8'd5});
        exp_q.push_back({2'd3, 1'b0, 8'd6});
        shot(o, 1'b0, 30, tv);
        chk("stall_rec_latency", tv, 11);
        rand_ready = 1'b0;
        ready_val  = 1'b1;

        // Continuous mode: two starts 100 cycles apart
        o = '{10, 10, 10, 10};
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < NCH; c++) exp_q.push_back({CH_W'(c), 1'b0, 8'd10});
        mode_i = 1'b1;
        arm_i  = 1'b1;
        tick(1);
        arm_i  = 1'b0;
        busy_low = 1'b0;
        for (int rel = 0; rel < 200; rel++) begin
            drive_rel(rel % 100, o, 1'b0);
            if (rel == 100) mode_i = 1'b0;
            if (rel < 110 && !busy_o) busy_low = 1'b1;
            if (rel == 110) chk("cont_missed", missed_o, 0);
            tick(1);
        end
        chk("cont_busy_held", busy_low, 0);
        chk("cont_records_left", exp_q.size(), 0);
        chk("cont_idle_after", busy_o, 0);

        // Start while IDLE is flagged and cleared by arm
        start_i = 1'b1;
        tick(3);
        start_i = 1'b0;
        tick(6);
        chk("missed_set_idle", missed_o, 1);
        chk("missed_no_rec", rec_valid_o, 0);
        arm_i = 1'b1;
        tick(1);
        arm_i = 1'b0;
        chk("missed_cleared", missed_o, 0);
        chk("missed_busy", busy_o, 1);
        o = '{4, 7, 7, 2};
        exp_q.push_back({2'd0, 1'b0, 8'd4});
        exp_q.push_back({2'd1, 1'b0, 8'd7});
        exp_q.push_back({2'd2, 1'b0, 8'd7});
        exp_q.push_back({2'd3, 1'b0, 8'd2});
        shot(o, 1'b0, 0, tv);

        // Async reset mid-measure after ch0 stopped, with a stray start pending
        o = '{5, -1, -1, -1};
        arm_i = 1'b1;
        tick(1);
        arm_i = 1'b0;
        for (int rel = 0; rel < 12; rel++) begin
            drive_rel(rel, o, 1'b0);
            start_i = (rel < 3) || (rel >= 6 && rel < 8);
            if (rel == 11) chk("missed_in_measure", missed_o, 1);
            tick(1);
        end
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_valid", rec_valid_o, 0);
        chk("rst_mid_data", rec_data_o, 0);
        chk("rst_mid_missed", missed_o, 0);
        start_i = 1'b0;
        stop_i  = '0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        o = '{3, 8, 1, 15};
        exp_q.push_back({2'd0, 1'b0, 8'd3});
        exp_q.push_back({2'd1, 1'b0, 8'd8});
        exp_q.push_back({2'd2, 1'b0, 8'd1});
        exp_q.push_back({2'd3, 1'b0, 8'd15});
        shot(o, 1'b1, 0, tv);

        // Randomized shots with random consumer back-pressure
        rand_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            int r;
            bit ex;
            for (int c = 0; c < NCH; c++) begin
                r = int'($urandom_range(0, 9));
                o[c] = (r == 0) ? -1 : (r == 1) ? 0 : int'($urandom_range(1, 60));
            end
            ex = 1'($urandom_range(0, 1));
            for (int c = 0; c < NCH; c++) exp_q.push_back(model_rec(c, o[c], ex));
            shot(o, ex, 0, tv);
            chk("rand_missed", missed_o, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tdc_mc_core.md
# tdc_mc_core

Parametrised multi-channel coarse time-to-digital converter core: measures the interval from one shared start edge to the first stop edge on each of `NCH` channels, in clock cycles. Generalises the single-channel ring-oscillator TDC tile to N channels, with a saturating timeout, single-shot/continuous modes and a record FIFO read through a valid/ready port. Sits between the asynchronous pad inputs and the byte-wide readout logic of the top-level user project.

## Interface
- `NCH`, 4: number of stop channels (1..8)
- `CNT_W`, 16: interval counter width
- `FIFO_DEPTH`, 8: record FIFO depth, power of two, ≥2
- `SYNC_STAGES`, 2: synchroniser flops per async input (≥2)

- `clk` in 1: single clock; all logic on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start_i` in 1: async start pulse/level; rising edge starts measurement
- `stop_i` in NCH: async stop inputs; rising edge stops that channel
- `arm_i` in 1: 1-cycle request to arm; honoured only in IDLE
- `mode_i` in 1: 0 = single-shot, 1 = continuous (auto re-arm after drain)
- `busy_o` out 1: state ≠ IDLE
- `rec_valid_o` out 1: FIFO not empty
- `rec_ready_i` in 1: consumer accepts record when `rec_valid_o & rec_ready_i`
- `rec_data_o` out CNT_W+1+CH_W: `{ch_id[CH_W-1:0], ovf, count[CNT_W-1:0]}`, CH_W = max(1,$clog2(NCH))
- `missed_o` out 1: sticky; a start edge arrived outside ARMED. Cleared by accepted `arm_i`.

## Operation
- Each async input passes through `SYNC_STAGES` flops plus a rising-edge detector; all inputs share identical latency.
- States: IDLE → ARMED (on `arm_i`) → MEASURE (on start edge; counter := 0) → DRAIN (all channels stopped, or counter reaches 2^CNT_W−1) → IDLE (`mode_i`=0) or ARMED (`mode_i`=1, sampled at DRAIN exit).
- MEASURE: counter increments every cycle, saturating. First stop edge on channel c captures counter+1 = cycles between start-edge-detect cycle and stop-edge-detect cycle (min 1). Later stop edges on c ignored.
- Stop edges outside MEASURE, including the start-edge-detect cycle, are ignored.
- Timeout: on saturation, every unstopped channel records ovf=1, count=all-ones; stopped channels keep their values with ovf=0.
- DRAIN: one record pushed per cycle, channel 0 upward. FIFO full → hold channel index and stall; records never dropped.
- Start edge in IDLE/MEASURE/DRAIN sets `missed_o`; it does not restart.
- FIFO: push permitted when not full or when a pop occurs the same cycle; simultaneous push/pop at full keeps occupancy at DEPTH. Pop when empty impossible (valid low).

## Timing
- Reset values: state IDLE, counter 0, FIFO empty, `busy_o`=0, `rec_valid_o`=0, `rec_data_o`=0, `missed_o`=0, captured counts 0.
- Input-to-edge-detect latency: SYNC_STAGES+1 cycles (cancels in interval).
- `arm_i` at cycle t → `busy_o`=1 at t+1.
- Last stop detect at t → DRAIN at t+1; first record visible (`rec_valid_o`) at t+2.
- `rec_data_o` is FIFO head, registered storage, combinational read; valid during pop cycle, next record at t+1.
- Async reset mid-MEASURE or DRAIN: discard all records, return to IDLE immediately.

## Structure
- Package `tdc_pkg`: state enum (IDLE, ARMED, MEASURE, DRAIN), record field width helper functions, mode encoding constants.
- Sub-module `tdc_sync_edge` (synchroniser + rising-edge detector, `SYNC_STAGES` param), instantiated NCH+1 times. FIFO and FSM inline in `tdc_mc_core`.

## Test plan
- NCH=4, `mode_i`=0, arm, start, stops at +5,+9,+12,+20 cycles (ch0..3) → records {0,0,5},{1,0,9},{2,0,12},{3,0,20} in order, then IDLE.
- CNT_W=8, only ch1 stops at +30 → ch1 {1,0,30}; ch0/2/3 ovf=1, count=255; DRAIN entered 255 cycles after start.
- FIFO_DEPTH=2, `rec_ready_i`=0 during DRAIN → two records buffered, DRAIN stalls; raise ready → remaining two emerge, none lost.
- `mode_i`=1, two start pulses 100 cycles apart, stops at +10 each → 8 records, `busy_o` stays 1; second start after re-arm, `missed_o`=0.
- Start pulse while IDLE → `missed_o`=1, no records; `arm_i` → `missed_o`=0.
- Assert `rst_n`=0 mid-MEASURE after ch0 stopped → FIFO empty, all outputs at reset values next cycle; re-arm measures correctly.
